wave_seq_scheduler: RTL and testbench

- Sequences the two-tone waveform datapath through a programmable list of (frequency word, duration) segments.
- Generalises the fixed high/low alternation to up to DEPTH segments, with optional looping.
- Sits between the host configuration interface and the phase-accumulator/waveform generator, which consumes freq_word each cycle.

---
 rtl/wave_seq_scheduler_pkg.sv | 22 ++
 rtl/wave_seq_scheduler_if.sv | 33 +++
 rtl/wave_seq_scheduler_seg_table.sv | 49 ++++
 rtl/wave_seq_scheduler.sv | 144 ++++++++++++++
 tb/tb_wave_seq_scheduler.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wave_seq_scheduler_pkg.sv
// ==== wavegen_pkg : shared types and defaults for the segment sequencer (rev 1.0) ====
`default_nettype none

package wavegen_pkg;

  localparam int FW_DEFAULT        = 13;
  localparam int DW_DEFAULT        = 16;
  localparam int IDLE_WORD_DEFAULT = 0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [FW_DEFAULT-1:0] freq;
    logic [DW_DEFAULT-1:0] dur;
  } seg_t;

endpackage

`default_nettype wire

// File: rtl/wave_seq_scheduler_if.sv
// ==== wave_seq_scheduler_if : host config/control and datapath-facing bus (rev 1.0) ====
`default_nettype none

interface wave_seq_scheduler_if #(
  parameter int DEPTH = 8,
  parameter int FW    = 13,
  parameter int DW    = 16
);
  logic                       cfg_we;
  logic [$clog2(DEPTH)-1:0]   cfg_addr;
  logic [FW-1:0]              cfg_freq;
  logic [DW-1:0]              cfg_dur;
  logic [$clog2(DEPTH):0]     num_seg;
  logic                       loop_en;
  logic                       start;
  logic                       stop;
  logic [FW-1:0]              freq_word;
  logic                       busy;
  logic [$clog2(DEPTH)-1:0]   seg_idx;
  logic                       done;

  modport master (
    output cfg_we, cfg_addr, cfg_freq, cfg_dur, num_seg, loop_en, start, stop,
    input  freq_word, busy, seg_idx, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_freq, cfg_dur, num_seg, loop_en, start, stop,
    output freq_word, busy, seg_idx, done
  );
endinterface

`default_nettype wire

// File: rtl/wave_seq_scheduler_seg_table.sv
// ==== wave_seg_table : DEPTH-entry segment register file, write-through read (rev 1.0) ====
`default_nettype none

module wave_seg_table
  import wavegen_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int FW    = FW_DEFAULT,
  parameter int DW    = DW_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [FW-1:0]            wfreq,
  input  logic [DW-1:0]            wdur,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [FW-1:0]            rfreq,
  output logic [DW-1:0]            rdur
);

  logic [FW-1:0] freq_mem [DEPTH];
  logic [DW-1:0] dur_mem  [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        freq_mem[i] <= '0;
        dur_mem[i]  <= '0;
      end
    end else if (we) begin
      freq_mem[waddr] <= wfreq;
      dur_mem[waddr]  <= wdur;
    end
  end

  // A same-cycle write to the fetched entry must be seen by the fetch
  always_comb begin
    rfreq = freq_mem[raddr];
    rdur  = dur_mem[raddr];
    if (we && (waddr == raddr)) begin
      rfreq = wfreq;
      rdur  = wdur;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wave_seq_scheduler.sv
// ==== wave_seq_scheduler : steps freq_word through a (freq, duration) table (rev 1.0) ====
`default_nettype none

module wave_seq_scheduler
  import wavegen_pkg::*;
#(
  parameter int            DEPTH     = 8,
  parameter int            FW        = FW_DEFAULT,
  parameter int            DW        = DW_DEFAULT,
  parameter logic [FW-1:0] IDLE_WORD = FW'(IDLE_WORD_DEFAULT)
) (
  input  logic                clock,
  input  logic                reset,
  wave_seq_scheduler_if.slave bus
);

  localparam int            AW      = $clog2(DEPTH);
  localparam int            NW      = AW + 1;
  localparam logic [NW-1:0] DEPTH_N = NW'(DEPTH);

  state_t          state, state_next;
  logic [FW-1:0]   freq_reg, freq_next;
  logic            busy_reg, busy_next;
  logic [AW-1:0]   idx_reg, idx_next;
  logic            done_reg, done_next;
  logic [DW-1:0]   cnt_reg, cnt_next;
  logic [DW-1:0]   term_reg, term_next;
  logic [NW-1:0]   num_reg, num_next;
  logic            loop_reg, loop_next;

  logic [AW-1:0]   fetch_addr;
  logic [FW-1:0]   fetch_freq;
  logic [DW-1:0]   fetch_dur;
  logic [DW-1:0]   fetch_term;
  logic            last_seg;
  logic [AW-1:0]   next_idx;
  logic [NW-1:0]   num_clamped;

  wave_seg_table #(
    .DEPTH (DEPTH),
    .FW    (FW),
    .DW    (DW)
  ) u_table (
    .clock (clock),
    .reset (reset),
    .we    (bus.cfg_we),
    .waddr (bus.cfg_addr),
    .wfreq (bus.cfg_freq),
    .wdur  (bus.cfg_dur),
    .raddr (fetch_addr),
    .rfreq (fetch_freq),
    .rdur  (fetch_dur)
  );

  assign last_seg    = ({1'b0, idx_reg} == (num_reg - NW'(1)));
  assign next_idx    = last_seg ? '0 : idx_reg + AW'(1);
  assign fetch_addr  = (state == IDLE) ? '0 : next_idx;
  // Terminal count is max(dur,1)-1, so dur=0 behaves as a one-cycle segment
  assign fetch_term  = (fetch_dur == '0) ? '0 : fetch_dur - DW'(1);
  assign num_clamped = (bus.num_seg > DEPTH_N) ? DEPTH_N : bus.num_seg;

  always_comb begin
    state_next = state;
    freq_next  = freq_reg;
    busy_next  = busy_reg;
    idx_next   = idx_reg;
    done_next  = 1'b0;
    cnt_next   = cnt_reg;
    term_next  = term_reg;
    num_next   = num_reg;
    loop_next  = loop_reg;

    if (state == IDLE) begin
      freq_next = IDLE_WORD;
      busy_next = 1'b0;
      idx_next  = '0;
      cnt_next  = '0;
      if (bus.start && !bus.stop && (bus.num_seg != '0)) begin
        state_next = RUN;
        num_next   = num_clamped;
        loop_next  = bus.loop_en;
        freq_next  = fetch_freq;
        term_next  = fetch_term;
        busy_next  = 1'b1;
      end
    end else begin
      if (bus.stop) begin
        state_next = IDLE;
        freq_next  = IDLE_WORD;
        busy_next  = 1'b0;
        idx_next   = '0;
        cnt_next   = '0;
      end else if (cnt_reg == term_reg) begin
        if (last_seg && !loop_reg) begin
          state_next = IDLE;
          freq_next  = IDLE_WORD;
          busy_next  = 1'b0;
          idx_next   = '0;
          cnt_next   = '0;
          done_next  = 1'b1;
        end else begin
          freq_next = fetch_freq;
          term_next = fetch_term;
          idx_next  = next_idx;
          cnt_next  = '0;
        end
      end else begin
        cnt_next = cnt_reg + DW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      freq_reg <= IDLE_WORD;
      busy_reg <= 1'b0;
      idx_reg  <= '0;
      done_reg <= 1'b0;
      cnt_reg  <= '0;
      term_reg <= '0;
      num_reg  <= '0;
      loop_reg <= 1'b0;
    end else begin
      state    <= state_next;
      freq_reg <= freq_next;
      busy_reg <= busy_next;
      idx_reg  <= idx_next;
      done_reg <= done_next;
      cnt_reg  <= cnt_next;
      term_reg <= term_next;
      num_reg  <= num_next;
      loop_reg <= loop_next;
    end
  end

  assign bus.freq_word = freq_reg;
  assign bus.busy      = busy_reg;
  assign bus.seg_idx   = idx_reg;
  assign bus.done      = done_reg;

endmodule

`default_nettype wire

// File: tb/tb_wave_seq_scheduler.sv
// ==== tb_wave_seq_scheduler : scoreboard bench for the segment sequencer (rev 1.0) ====
`default_nettype none

module tb_wave_seq_scheduler;
  import wavegen_pkg::*;

  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  wave_seq_scheduler_if #(.DEPTH(DEPTH), .FW(13), .DW(16)) bus ();

  wave_seq_scheduler #(
    .DEPTH     (DEPTH),
    .FW        (13),
    .DW        (16),
    .IDLE_WORD (13'd0)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [12:0] f;
    logic        b;
    logic [2:0]  i;
    logic        d;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic exp_t sample();
    exp_t s;
    s.f = bus.freq_word;
    s.b = bus.busy;
    s.i = bus.seg_idx;
    s.d = bus.done;
    return s;
  endfunction

  function automatic string fmt(exp_t s);
    return $sformatf("freq=%0d busy=%0b idx=%0d done=%0b", s.f, s.b, s.i, s.d);
  endfunction

  task automatic push(input int f, input bit b, input int i, input bit d);
    exp_t s;
    s.f = 13'(f);
    s.b = b;
    s.i = 3'(i);
    s.d = d;
    sb.push_back(s);
  endtask

  task automatic push_seg(input int f, input int dur, input int idx);
    for (int k = 0; k < ((dur == 0) ? 1 : dur); k++) push(f, 1'b1, idx, 1'b0);
  endtask

  task automatic push_idle(input bit d);
    push(0, 1'b0, 0, d);
  endtask

  task automatic write_entry(input int a, input int f, input int d);
    seg_t s;
    s.freq = 13'(f);
    s.dur  = 16'(d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 3'(a);
    bus.cfg_freq = s.freq;
    bus.cfg_dur  = s.dur;
    @(posedge clock); #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    exp_t e, g;
    repeat (3) push_idle(1'b0);
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      e = sb.pop_front(); g = sample(); n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL reset cyc %0d: got %s expected %s", k, fmt(g), fmt(e)); end
      if (k == 1) reset = 1'b0;
    end
  endtask

  task automatic test_single_shot();
    int n;
    exp_t e, g;
    write_entry(0, 88, 3);
    write_entry(1, 13, 2);
    bus.num_seg = 4'd2; bus.loop_en = 1'b0; bus.start = 1'b1;
    push_seg(88, 3, 0); push_seg(13, 2, 1); push_idle(1'b1); push_idle(1'b0);
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      e = sb.pop_front(); g = sample(); n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL single_shot cyc %0d: got %s expected %s", k, fmt(g), fmt(e)); end
      if (k == 0) bus.start = 1'b0;
    end
  endtask

  task automatic test_loop_stop();
    int n;
    exp_t e, g;
    bus.num_seg = 4'd2; bus.loop_en = 1'b1; bus.start = 1'b1;
    for (int p = 0; p < 3; p++) begin push_seg(88, 3, 0); push_seg(13, 2, 1); end
    push(88, 1'b1, 0, 1'b0); push(88, 1'b1, 0, 1'b0);
    push_idle(1'b0); push_idle(1'b0);
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      e = sb.pop_front(); g = sample(); n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL loop_stop cyc %0d: got %s expected %s", k, fmt(g), fmt(e)); end
      if (k == 0)  bus.start = 1'b0;
      if (k == 16) bus.stop  = 1'b1;
      if (k == 17) bus.stop  = 1'b0;
    end
  endtask

  task automatic test_dur_zero();
    int n;
    exp_t e, g;
    write_entry(0, 77, 0);
    bus.num_seg = 4'd1; bus.loop_en = 1'b0; bus.start = 1'b1;
    push(77, 1'b1, 0, 1'b0); push_idle(1'b1); push_idle(1'b0);
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      e = sb.pop_front(); g = sample(); n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL dur_zero cyc %0d: got %s expected %s", k, fmt(g), fmt(e)); end
      if (k == 0) bus.start = 1'b0;
    end
  endtask

  task automatic test_write_while_running();
    int n;
    exp_t e, g;
    write_entry(0, 88, 3);
    bus.num_seg = 4'd2; bus.loop_en = 1'b1; bus.start = 1'b1;
    push_seg(88, 3, 0); push_seg(13, 2, 1); push_seg(50, 1, 0); push_seg(99, 4, 1);
    push_seg(50, 1, 0); push_idle(1'b0); push_idle(1'b0);
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      e = sb.pop_front(); g = sample(); n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL write_running cyc %0d: got %s expected %s", k, fmt(g), fmt(e)); end
      if (k == 0) bus.start = 1'b0;
      if (k == 3) begin bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_freq = 13'd50; bus.cfg_dur = 16'd1; end
      if (k == 4) begin bus.cfg_addr = 3'd1; bus.cfg_freq = 13'd99; bus.cfg_dur = 16'd4; end
      if (k == 5) bus.cfg_we = 1'b0;
      if (k == 10) bus.stop = 1'b1;
      if (k == 11) bus.stop = 1'b0;
    end
  endtask

  task automatic test_ignored_start();
    int n;
    exp_t e, g;
    bus.num_seg = 4'd0; bus.loop_en = 1'b0; bus.start = 1'b1;
    repeat (3) push_idle(1'b0);
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      e = sb.pop_front(); g = sample(); n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL start_num0 cyc %0d: got %s expected %s", k, fmt(g), fmt(e)); end
      if (k == 2) bus.start = 1'b0;
    end
    bus.num_seg = 4'd2; bus.start = 1'b1; bus.stop = 1'b1;
    repeat (3) push_idle(1'b0);
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      e = sb.pop_front(); g = sample(); n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL start_stop cyc %0d: got %s expected %s", k, fmt(g), fmt(e)); end
      if (k == 2) begin bus.start = 1'b0; bus.stop = 1'b0; end
    end
    bus.start = 1'b1;
    push_seg(50, 1, 0); push_seg(99, 4, 1); push_idle(1'b1); push_idle(1'b0);
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      e = sb.pop_front(); g = sample(); n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL start_in_run cyc %0d: got %s expected %s", k, fmt(g), fmt(e)); end
      if (k == 0) bus.start = 1'b0;
      if (k == 2) bus.start = 1'b1;
      if (k == 3) bus.start = 1'b0;
    end
  endtask

  task automatic test_clamp();
    int n;
    exp_t e, g;
    bus.num_seg = 4'd15; bus.loop_en = 1'b0; bus.start = 1'b1;
    push_seg(50, 1, 0); push_seg(99, 4, 1);
    for (int s = 2; s < DEPTH; s++) push_seg(0, 0, s);
    push_idle(1'b1); push_idle(1'b0);
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      e = sb.pop_front(); g = sample(); n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL clamp cyc %0d: got %s expected %s", k, fmt(g), fmt(e)); end
      if (k == 0) bus.start = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    exp_t e, g;
    bus.num_seg = 4'd1; bus.loop_en = 1'b0; bus.start = 1'b1;
    push_seg(50, 1, 0); push_idle(1'b1); push_seg(50, 1, 0); push_idle(1'b1); push_idle(1'b0);
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      e = sb.pop_front(); g = sample(); n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL back_to_back cyc %0d: got %s expected %s", k, fmt(g), fmt(e)); end
      if (k == 2) bus.start = 1'b0;
    end
  endtask

  task automatic test_mid_reset();
    int n;
    exp_t e, g;
    write_entry(0, 88, 3);
    write_entry(1, 13, 2);
    bus.num_seg = 4'd2; bus.loop_en = 1'b0; bus.start = 1'b1;
    push_seg(88, 3, 0); push(13, 1'b1, 1, 1'b0); push_idle(1'b0);
    push_seg(0, 0, 0); push_idle(1'b1); push_idle(1'b0);
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      e = sb.pop_front(); g = sample(); n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL mid_reset cyc %0d: got %s expected %s", k, fmt(g), fmt(e)); end
      if (k == 0) bus.start = 1'b0;
      if (k == 3) reset = 1'b1;
      if (k == 4) begin reset = 1'b0; bus.num_seg = 4'd1; bus.start = 1'b1; end
      if (k == 5) bus.start = 1'b0;
    end
  endtask

  initial begin
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_freq = '0;
    bus.cfg_dur  = '0;
    bus.num_seg  = '0;
    bus.loop_en  = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;

    test_reset();
    test_single_shot();
    test_loop_stop();
    test_dur_zero();
    test_write_while_running();
    test_ignored_start();
    test_clamp();
    test_back_to_back();
    test_mid_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
